// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for an 8-bit accumulator-style datapath.
// Walks FETCH/DECODE/EXEC/(MEMWAIT)/WB per instruction and counts retirements.
module instr_sequencer #(
   parameter int OPW  = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      ir,
   input  logic            zero_flag,
   input  logic            mem_ready,
   output logic            ir_load,
   output logic            iram_rd,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            dram_rd,
   output logic            dram_wr,
   output logic            reg_we,
   output logic [1:0]      alu_op,
   output logic            halted,
   output logic            illegal,
   output logic [CNTW-1:0] instr_count,
   output logic [2:0]      dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMWAIT, S_WB, S_HALT
   } state_t;

   localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
   localparam logic [OPW-1:0] OP_LOAD  = OPW'(1);
   localparam logic [OPW-1:0] OP_STORE = OPW'(2);
   localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
   localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
   localparam logic [OPW-1:0] OP_JMP   = OPW'(5);
   localparam logic [OPW-1:0] OP_JMPZ  = OPW'(6);
   localparam logic [OPW-1:0] OP_HALT  = OPW'(15);

   state_t          state_q, state_d;
   logic [OPW-1:0]  opc_in, opc_q;
   logic            opc_legal, ill_q, zero_q;
   logic [CNTW-1:0] cnt_q;
   logic            unused_ir;

   assign opc_in    = ir[7 -: OPW];
   assign unused_ir = ^ir;

   always_comb begin
      opc_legal = 1'b0;
      case (opc_in)
         OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
         OP_JMP, OP_JMPZ, OP_HALT: opc_legal = 1'b1;
         default:                  opc_legal = 1'b0;
      endcase
   end

   // Illegal opcodes are stored as NOP so EXEC/WB need no special case.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         opc_q   <= OP_NOP;
         ill_q   <= 1'b0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            opc_q <= opc_legal ? opc_in : OP_NOP;
            ill_q <= ~opc_legal;
         end
         if (state_q == S_EXEC)
            zero_q <= zero_flag;
         if (state_q == S_WB)
            cnt_q <= cnt_q + CNTW'(1);
      end
   end

   // Memory handshake: the dram strobe stays high from EXEC through every
   // MEMWAIT cycle; the transfer completes in the cycle mem_ready is 1.
   always_comb begin
      state_d = state_q;
      ir_load = 1'b0;
      iram_rd = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      dram_rd = 1'b0;
      dram_wr = 1'b0;
      reg_we  = 1'b0;
      alu_op  = 2'b00;
      halted  = 1'b0;
      illegal = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            iram_rd = 1'b1;
            ir_load = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            illegal = ill_q;
            if (opc_q == OP_ADD) alu_op = 2'b01;
            if (opc_q == OP_SUB) alu_op = 2'b10;
            if (opc_q == OP_LOAD) begin
               dram_rd = 1'b1;
               state_d = S_MEMWAIT;
            end else if (opc_q == OP_STORE) begin
               dram_wr = 1'b1;
               state_d = S_MEMWAIT;
            end else if (opc_q == OP_HALT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEMWAIT: begin
            dram_rd = (opc_q == OP_LOAD);
            dram_wr = (opc_q == OP_STORE);
            if (mem_ready) state_d = S_WB;
         end
         S_WB: begin
            reg_we = (opc_q == OP_LOAD) || (opc_q == OP_ADD) || (opc_q == OP_SUB);
            if ((opc_q == OP_JMP) || ((opc_q == OP_JMPZ) && zero_q))
               pc_load = 1'b1;
            else
               pc_inc = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign instr_count = cnt_q;
   assign dbg_state   = state_q;

endmodule
